// File: rtl/fifo_sr_pkg.sv
// Shared types for the shift-register FIFO drain stage.
package fifo_sr_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} drain_state_t;

endpackage

// File: rtl/fifo_sr_drain.sv
// Drains the shift-register FIFO pop port into a registered valid/ready stream
// through a 2-entry buffer, so out_ready never reaches fifo_pop combinationally.
module fifo_sr_drain
    import fifo_sr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_empty_r,
    output logic         fifo_pop,
    input  logic         fifo_pop_data_valid,
    input  logic [W-1:0] fifo_pop_data,
    input  logic         flush,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    drain_state_t state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         cap;
    logic         deq;

    // Room for a word exists whenever fewer than two are held; the pop
    // decision looks only at registered state and upstream flags.
    assign fifo_pop  = !rst && !flush && !fifo_empty_r && (state_q != TWO);
    assign cap       = fifo_pop_data_valid;

    assign out_valid = !rst && (state_q != EMPTY);
    assign busy      = out_valid;
    assign out_data  = out_valid ? a_q : '0;
    assign deq       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            EMPTY: begin
                if (cap) begin
                    state_d = ONE;
                    a_d     = fifo_pop_data;
                end
            end
            ONE: begin
                if (cap && deq) begin
                    a_d = fifo_pop_data;
                end else if (cap) begin
                    state_d = TWO;
                    b_d     = fifo_pop_data;
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (deq) begin
                    state_d = ONE;
                    a_d     = b_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Data slots carry no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

`ifndef SYNTHESIS
    a_cap_eq_pop: assert property (@(posedge clk) fifo_pop_data_valid == fifo_pop);
    a_no_cap_two: assert property (@(posedge clk) disable iff (rst) !(cap && state_q == TWO));
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));
    a_state_legal: assert property (@(posedge clk) 2'(state_q) != 2'b11);
`endif

endmodule

// File: tb/tb_fifo_sr_drain.sv
// Directed bench for fifo_sr_drain: an upstream FIFO model feeds the DUT and a
// scoreboard monitor checks every delivered word against push order.
module tb_fifo_sr_drain;

    logic        clk;
    logic        rst;
    logic        fifo_empty_r;
    logic        fifo_pop;
    logic        fifo_pop_data_valid;
    logic [31:0] fifo_pop_data;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];
    logic        pop_seen;
    int          checks;
    int          errors;

    fifo_sr_drain #(.W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_empty_r        (fifo_empty_r),
        .fifo_pop            (fifo_pop),
        .fifo_pop_data_valid (fifo_pop_data_valid),
        .fifo_pop_data       (fifo_pop_data),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_ready           (out_ready),
        .busy                (busy)
    );

    assign fifo_pop_data_valid = fifo_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic upd();
        fifo_empty_r  = (fq.size() == 0);
        fifo_pop_data = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        upd();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words still buffered in the DUT at a flush/reset are lost; those left
    // in the upstream FIFO remain expected.
    task automatic drop_buffered();
        while (exp_q.size() > fq.size()) void'(exp_q.pop_front());
    endtask

    // Upstream FIFO: head leaves the queue after the edge that ends a pop cycle.
    always @(negedge clk) pop_seen = fifo_pop;
    always begin
        @(posedge clk);
        #1;
        if (pop_seen) begin
            void'(fq.pop_front());
            upd();
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) chk("idle_data_zero", out_data, 32'h0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected no word", out_data);
                end else begin
                    chk("sb_order", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        pop_seen  = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        upd();
        tick();
        tick();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_pop", {31'h0, fifo_pop}, 32'h0);

        // single word latency
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'h0000_00A1);
        #1;
        chk("t1_pop_c0", {31'h0, fifo_pop}, 32'h1);
        tick(); #1;
        chk("t1_valid_c1", {31'h0, out_valid}, 32'h1);
        chk("t1_data_c1", out_data, 32'h0000_00A1);
        tick();

        // full-rate streaming
        for (int i = 0; i < 16; i++) push(32'h10 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t2_pop", {31'h0, fifo_pop}, 32'h1);
            tick(); #1;
            chk("t2_valid", {31'h0, out_valid}, 32'h1);
            chk("t2_data", out_data, 32'h10 + 32'(i));
        end
        tick();

        // backpressure fills both slots
        out_ready = 1'b0;
        push(32'h1); push(32'h2); push(32'h3);
        #1; chk("t3_pop_c0", {31'h0, fifo_pop}, 32'h1);
        tick(); #1; chk("t3_pop_c1", {31'h0, fifo_pop}, 32'h1);
        tick(); #1;
        chk("t3_pop_c2", {31'h0, fifo_pop}, 32'h0);
        chk("t3_data_c2", out_data, 32'h1);
        chk("t3_busy_c2", {31'h0, busy}, 32'h1);
        tick(); #1;
        chk("t3_pop_c3", {31'h0, fifo_pop}, 32'h0);
        chk("t3_data_c3", out_data, 32'h1);
        out_ready = 1'b1;
        tick(); #1; chk("t3_data_c4", out_data, 32'h2);
        tick(); #1; chk("t3_data_c5", out_data, 32'h3);
        tick();

        // flush from TWO with a same-cycle handshake
        out_ready = 1'b0;
        push(32'h5); push(32'h6); push(32'h7);
        tick(); tick();
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t4_pop_flush", {31'h0, fifo_pop}, 32'h0);
        chk("t4_data_flush", out_data, 32'h5);
        tick();
        flush = 1'b0;
        drop_buffered();
        #1;
        chk("t4_valid_after", {31'h0, out_valid}, 32'h0);
        chk("t4_data_after", out_data, 32'h0);
        chk("t4_pop_after", {31'h0, fifo_pop}, 32'h1);
        chk("t4_head_kept", fifo_pop_data, 32'h7);
        tick(); #1;
        chk("t4_data_resume", out_data, 32'h7);
        tick();

        // reset from TWO
        out_ready = 1'b0;
        push(32'h8); push(32'h9); push(32'hA);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t5_valid_rst", {31'h0, out_valid}, 32'h0);
        chk("t5_busy_rst", {31'h0, busy}, 32'h0);
        chk("t5_data_rst", out_data, 32'h0);
        chk("t5_pop_rst", {31'h0, fifo_pop}, 32'h0);
        tick();
        rst = 1'b0;
        drop_buffered();
        out_ready = 1'b1;
        #1;
        chk("t5_valid_rel", {31'h0, out_valid}, 32'h0);
        chk("t5_pop_rel", {31'h0, fifo_pop}, 32'h1);
        tick(); #1;
        chk("t5_valid_resume", {31'h0, out_valid}, 32'h1);
        chk("t5_data_resume", out_data, 32'hA);
        tick();

        // random backpressure over 1000 words
        for (int i = 0; i < 1000; i++) push($urandom);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 5000) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
        end
        chk("t6_drained", 32'(exp_q.size()), 32'h0);
        out_ready = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sr_drain.md
Name: fifo_sr_drain

Overview:
- Downstream stage of the one-hot shift-register FIFO.
- Drains the FIFO's pop interface (pop, pop_data_valid, pop_data, empty_r) into a registered valid/ready stream for consumers that apply backpressure.
- Holds up to two words in a 2-entry output buffer, so full throughput is sustained without a combinational path from out_ready to the FIFO pop.
- A synchronous flush discards buffered words without touching FIFO contents.

Parameters:
W, 32, data word width; must match the upstream FIFO W.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
fifo_empty_r  input  1  upstream FIFO registered empty flag
fifo_pop  output  1  pop request to upstream FIFO
fifo_pop_data_valid  input  1  upstream pop acknowledge; equals fifo_pop in the same cycle
fifo_pop_data  input  W  upstream head word, valid in the pop cycle
flush  input  1  discard all buffered words at the next edge
out_valid  output  1  output word available
out_data  output  W  output word; '0 when out_valid=0
out_ready  input  1  consumer accepts the word this cycle
busy  output  1  buffer occupancy non-zero

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: occupancy=0 (state EMPTY), out_valid=0, out_data='0, busy=0, fifo_pop=0 while rst=1. Data slots are not reset.
- Storage: slot A (head) and slot B.
- State is the occupancy: EMPTY (0), ONE (1), TWO (2). out_valid = (state!=EMPTY); busy = out_valid.
- fifo_pop = !rst && !flush && !fifo_empty_r && (state!=TWO). It depends only on registered state and inputs, never on out_ready.
- cap = fifo_pop_data_valid, which equals fifo_pop. fifo_pop_data is captured at the edge ending the pop cycle.
- deq = out_valid && out_ready.
- Latency: a word that is FIFO head in cycle t (empty_r=0, state EMPTY) appears on out_data in cycle t+1.
- Throughput: steady state ONE with out_ready=1 and FIFO non-empty gives one word per cycle.
- Transitions (flush=0):
  - EMPTY: cap -> ONE, A<=data.
  - ONE: cap&deq -> ONE, A<=data. cap&!deq -> TWO, B<=data. !cap&deq -> EMPTY. Neither -> ONE.
  - TWO: deq -> ONE, A<=B. !deq -> TWO. cap is impossible in TWO.
- Ordering: strict FIFO order; A is always the oldest word.
- Flush:
  - Next state is EMPTY regardless of cap/deq.
  - fifo_pop is forced 0 in the flush cycle, so no word is lost from the FIFO.
  - A handshake (out_valid&out_ready) in the flush cycle counts as delivered. Words not delivered are discarded.
- Reset mid-operation: identical to flush, plus out_data returns to '0.
- Assertions:
  - fifo_pop_data_valid==fifo_pop.
  - No cap when state TWO.
  - out_data stable while out_valid&&!out_ready.
  - state never encodes 3.
- Arithmetic: no width growth; data passes through unmodified.

Decomposition:
- Package fifo_sr_pkg:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} drain_state_t.
  - No other shared constants; W stays a module parameter.
- No sub-module. The 2-entry buffer and state machine fit in one module (roughly 150-200 lines).

Test Plan:
- Reset then FIFO non-empty with head 0x0000_00A1, out_ready=1 -> fifo_pop=1 in cycle 0, out_valid=1 with out_data=0x0000_00A1 in cycle 1, state ONE.
- Stream 0x10..0x1F with out_ready=1 throughout -> 16 words out in order in consecutive cycles, fifo_pop never deasserts while FIFO non-empty, state stays ONE.
- Words 0x1,0x2,0x3 with out_ready=0 -> fifo_pop high for 2 cycles only, state TWO, out_data=0x1 held, busy=1. Then out_ready=1 -> 0x1,0x2,0x3 delivered in order on consecutive cycles.
- State TWO (A=0x5,B=0x6), flush=1 and out_ready=1 in same cycle -> 0x5 counted delivered, next cycle out_valid=0, out_data=0, fifo_pop=0 during the flush cycle, FIFO head unchanged.
- State TWO, assert rst for 1 cycle -> out_valid=0, busy=0, out_data=0, fifo_pop=0 during reset. After release, draining resumes from the FIFO head with 1-cycle latency.
- Random out_ready (50%) over 1000 words -> scoreboard matches push order exactly, all assertions hold, no fifo_pop while state TWO.
